// File: rtl/sd_buf_pkg.sv
// Shared definitions for the SD sector buffer: FSM state codes, bus register
// offsets and the STATUS / CMD bit positions.
package sd_buf_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_RD_REQ    = 3'd1;
  localparam state_t S_RD_STREAM = 3'd2;
  localparam state_t S_WR_REQ    = 3'd3;
  localparam state_t S_WR_STREAM = 3'd4;
  localparam state_t S_FINISH    = 3'd5;
  localparam state_t S_ERROR     = 3'd6;

  localparam logic [1:0] REG_CMD  = 2'd0;
  localparam logic [1:0] REG_LBA  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_PTR  = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_READY   = 3;
  localparam int STAT_CNT_LSB = 16;

  localparam int CMD_RD = 0;
  localparam int CMD_WR = 1;

endpackage

// File: rtl/sd_buf_ram.sv
// Sector buffer RAM: two ports with registered reads. Port A serves the CPU,
// port B the byte stream; the two are never active at the same time.
module sd_buf_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    wdata_a,
  output logic [7:0]    rdata_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    wdata_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [DEPTH];

  // Read data only moves on a read access, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= wdata_a;
      else      rdata_a     <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= wdata_b;
      else      rdata_b     <= mem[addr_b];
    end
  end

endmodule

// File: rtl/sd_block_buffer.sv
// One-sector buffer between the CPU register bus and the byte-wide SD controller.
// Define SD_BUF_TIMEOUT_EN to enable the stall watchdog (STATUS.err, ERROR state).
module sd_block_buffer
  import sd_buf_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        iCLK,
  input  logic        reset_n,
  input  logic [1:0]  iBusAddr,
  input  logic        iBusWrite,
  input  logic        iBusRead,
  input  logic [31:0] iBusWData,
  output logic [31:0] oBusRData,
  output logic        oSdRd,
  output logic        oSdWr,
  output logic [31:0] oSdAddr,
  output logic [7:0]  oSdDin,
  input  logic [7:0]  iSdDout,
  input  logic        iSdByteAvail,
  input  logic        iSdReadyNext,
  input  logic        iSdReady
);

  localparam int PTR_W = $clog2(BLOCK_BYTES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_BYTES);
  localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYC - 1);

`ifdef SD_BUF_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_t           state_reg, state_next;
  logic             done_reg, err_reg;
  logic [31:0]      lba_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sd_rd_reg, sd_wr_reg;
  logic [7:0]       sd_din_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic             rdata_sel_reg, rdata_sel_next;
  logic             avail_q1, avail_q2, rnext_q1, rnext_q2;
  logic [23:0]      wd_reg;

  logic             busy, rd_strobe, cmd_ok, data_wr, data_rd;
  logic             avail_evt, rnext_evt, byte_in, byte_out, cnt_full, wd_trip;
  logic             stream_wr_side;
  logic [31:0]      status_word;
  logic [7:0]       ram_rdata_a, ram_rdata_b;
  logic [PTR_W-1:0] addr_b;

  assign busy      = (state_reg != S_IDLE);
  assign rd_strobe = iBusRead & ~iBusWrite;
  assign cmd_ok    = iBusWrite && (iBusAddr == REG_CMD) && iSdReady &&
                     ((state_reg == S_IDLE) || (state_reg == S_ERROR));
  assign data_wr   = iBusWrite && (iBusAddr == REG_DATA) && !busy;
  assign data_rd   = rd_strobe && (iBusAddr == REG_DATA) && !busy;

  assign avail_evt = avail_q1 & ~avail_q2;
  assign rnext_evt = rnext_q1 & ~rnext_q2;
  assign cnt_full  = (cnt_reg == CNT_FULL);
  assign byte_in   = (state_reg == S_RD_STREAM) && avail_evt && !cnt_full;
  assign byte_out  = (state_reg == S_WR_STREAM) && rnext_evt && !cnt_full;
  assign stream_wr_side = (state_reg == S_WR_REQ) || (state_reg == S_WR_STREAM);

  // Look one byte ahead on a consume event so oSdDin refreshes on the next cycle.
  assign addr_b  = byte_out ? cnt_reg[PTR_W-1:0] + PTR_W'(1) : cnt_reg[PTR_W-1:0];
  assign wd_trip = WD_EN && (state_reg != S_IDLE) && (state_reg != S_ERROR) &&
                   (wd_reg == WD_LIMIT);

  sd_buf_ram #(.DEPTH(BLOCK_BYTES)) u_ram (
    .clk     (iCLK),
    .en_a    (data_wr | data_rd),
    .we_a    (data_wr),
    .addr_a  (ptr_reg),
    .wdata_a (iBusWData[7:0]),
    .rdata_a (ram_rdata_a),
    .en_b    (byte_in | stream_wr_side),
    .we_b    (byte_in),
    .addr_b  (addr_b),
    .wdata_b (iSdDout),
    .rdata_b (ram_rdata_b)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_DONE]  = done_reg;
    status_word[STAT_ERR]   = err_reg;
    status_word[STAT_READY] = iSdReady;
    status_word[STAT_CNT_LSB +: CNT_W] = cnt_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_ERROR: begin
        if (cmd_ok) begin
          if (iBusWData[CMD_RD])      state_next = S_RD_REQ;
          else if (iBusWData[CMD_WR]) state_next = S_WR_REQ;
          else                        state_next = S_IDLE;
        end
      end
      S_RD_REQ:    if (!iSdReady) state_next = S_RD_STREAM;
      S_WR_REQ:    if (!iSdReady) state_next = S_WR_STREAM;
      S_RD_STREAM: if (cnt_full)  state_next = S_FINISH;
      S_WR_STREAM: if (cnt_full)  state_next = S_FINISH;
      S_FINISH:    if (iSdReady)  state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (wd_trip) state_next = S_ERROR;
  end

  // DATA reads are served straight from the RAM output register via rdata_sel.
  always_comb begin
    rdata_next     = rdata_reg;
    rdata_sel_next = rdata_sel_reg;
    if (rd_strobe) begin
      rdata_sel_next = 1'b0;
      case (iBusAddr)
        REG_CMD:  rdata_next = status_word;
        REG_LBA:  rdata_next = lba_reg;
        REG_DATA: begin
          rdata_next     = '0;
          rdata_sel_next = !busy;
        end
        default:  rdata_next = 32'(ptr_reg);
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      lba_reg       <= '0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      sd_rd_reg     <= 1'b0;
      sd_wr_reg     <= 1'b0;
      sd_din_reg    <= '0;
      rdata_reg     <= '0;
      rdata_sel_reg <= 1'b0;
      avail_q1      <= 1'b0;
      avail_q2      <= 1'b0;
      rnext_q1      <= 1'b0;
      rnext_q2      <= 1'b0;
      wd_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      rdata_reg     <= rdata_next;
      rdata_sel_reg <= rdata_sel_next;
      avail_q1      <= iSdByteAvail;
      avail_q2      <= avail_q1;
      rnext_q1      <= iSdReadyNext;
      rnext_q2      <= rnext_q1;
      sd_rd_reg     <= (state_next == S_RD_REQ);
      sd_wr_reg     <= (state_next == S_WR_REQ);

      if ((state_next != state_reg) || byte_in || byte_out) wd_reg <= '0;
      else                                                   wd_reg <= wd_reg + 24'd1;

      if (cmd_ok) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
        cnt_reg  <= '0;
      end else if (byte_in || byte_out) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      if (wd_trip) err_reg <= 1'b1;
      if ((state_reg == S_FINISH) && (state_next == S_IDLE)) done_reg <= 1'b1;

      if (stream_wr_side && !cnt_full) sd_din_reg <= ram_rdata_b;

      if (iBusWrite && (iBusAddr == REG_LBA) && !busy) lba_reg <= iBusWData;

      if (iBusWrite && (iBusAddr == REG_PTR)) ptr_reg <= iBusWData[PTR_W-1:0];
      else if (data_wr || data_rd)            ptr_reg <= ptr_reg + PTR_W'(1);
    end
  end

  assign oBusRData = rdata_sel_reg ? {24'b0, ram_rdata_a} : rdata_reg;
  assign oSdRd     = sd_rd_reg;
  assign oSdWr     = sd_wr_reg;
  assign oSdAddr   = lba_reg;
  assign oSdDin    = sd_din_reg;

endmodule
